// File: rtl/game_sound_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_sound_sequencer_if                                      |
// | Description : Event inputs and tone outputs of the game sound sequencer.   |
// |               SOUND_COLLISION_EN adds the collisionPulse event line.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface game_sound_sequencer_if #(
  parameter int TONE_W = 4
) ();
  logic              startOfFrame;
  logic              winPulse;
  logic              losePulse;
  logic              scoredPulse;
`ifdef SOUND_COLLISION_EN
  logic              collisionPulse;
`endif
  logic              tone_en;
  logic [TONE_W-1:0] tone_idx;
  logic              busy;
  logic [1:0]        cur_event;
  logic              seq_done;

`ifdef SOUND_COLLISION_EN
  modport master (
    output startOfFrame, winPulse, losePulse, scoredPulse, collisionPulse,
    input  tone_en, tone_idx, busy, cur_event, seq_done
  );
  modport slave (
    input  startOfFrame, winPulse, losePulse, scoredPulse, collisionPulse,
    output tone_en, tone_idx, busy, cur_event, seq_done
  );
`else
  modport master (
    output startOfFrame, winPulse, losePulse, scoredPulse,
    input  tone_en, tone_idx, busy, cur_event, seq_done
  );
  modport slave (
    input  startOfFrame, winPulse, losePulse, scoredPulse,
    output tone_en, tone_idx, busy, cur_event, seq_done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/game_sound_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_sound_sequencer                                         |
// | Description : Edge-detects game events and plays a per-event note ROM,     |
// |               timed in video frames; higher-priority events preempt.       |
// |               SOUND_COLLISION_EN enables the lowest-priority click event.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module game_sound_sequencer #(
  parameter int GAP_FRAMES = 1,
  parameter int TONE_W     = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  game_sound_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [5:0] c_gap_frames = 6'(GAP_FRAMES);

  logic [1:0]        r_state, w_next_state;
  logic [3:0]        w_in, r_in_d, w_rise, r_pend;
  logic [1:0]        r_cur_event, r_note_ptr, w_sel_ev;
  logic [5:0]        r_dur_cnt, r_gap_cnt;
  logic [TONE_W-1:0] r_tone_idx;
  logic              r_seq_done;
  logic              w_any_pend, w_preempt;
  logic              w_select, w_load, w_advance, w_done, w_dur_dec, w_gap_dec;
  logic [3:0]        w_rom_idx;
  logic [5:0]        w_rom_dur;
  logic              w_rom_last;

  // Event code doubles as bit position: 0=scored 1=win 2=lose 3=collision
`ifdef SOUND_COLLISION_EN
  assign w_in = {bus.collisionPulse, bus.losePulse, bus.winPulse, bus.scoredPulse};
`else
  assign w_in = {1'b0, bus.losePulse, bus.winPulse, bus.scoredPulse};
`endif

  always_comb begin
    w_rise = w_in & ~r_in_d;
`ifdef SOUND_COLLISION_EN
    if (r_state != S_IDLE) w_rise[3] = 1'b0;
`endif
  end

  function automatic logic [1:0] rank(input logic [1:0] ev);
    case (ev)
      2'd2:    rank = 2'd3;
      2'd1:    rank = 2'd2;
      2'd0:    rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  always_comb begin
    w_sel_ev = 2'd3;
    if (r_pend[2])      w_sel_ev = 2'd2;
    else if (r_pend[1]) w_sel_ev = 2'd1;
    else if (r_pend[0]) w_sel_ev = 2'd0;
  end

  assign w_any_pend = |r_pend;
  assign w_preempt  = w_any_pend && (rank(w_sel_ev) > rank(r_cur_event));

  always_comb begin
    w_rom_idx  = 4'd0;
    w_rom_dur  = 6'd1;
    w_rom_last = 1'b1;
    case ({r_cur_event, r_note_ptr})
      4'b00_00: begin w_rom_idx = 4'd8;  w_rom_dur = 6'd6;  w_rom_last = 1'b0; end
      4'b00_01: begin w_rom_idx = 4'd10; w_rom_dur = 6'd6;  end
      4'b01_00: begin w_rom_idx = 4'd8;  w_rom_dur = 6'd10; w_rom_last = 1'b0; end
      4'b01_01: begin w_rom_idx = 4'd10; w_rom_dur = 6'd10; w_rom_last = 1'b0; end
      4'b01_10: begin w_rom_idx = 4'd12; w_rom_dur = 6'd10; w_rom_last = 1'b0; end
      4'b01_11: begin w_rom_idx = 4'd15; w_rom_dur = 6'd20; end
      4'b10_00: begin w_rom_idx = 4'd7;  w_rom_dur = 6'd15; w_rom_last = 1'b0; end
      4'b10_01: begin w_rom_idx = 4'd5;  w_rom_dur = 6'd15; w_rom_last = 1'b0; end
      4'b10_10: begin w_rom_idx = 4'd3;  w_rom_dur = 6'd15; w_rom_last = 1'b0; end
      4'b10_11: begin w_rom_idx = 4'd0;  w_rom_dur = 6'd30; end
      4'b11_00: begin w_rom_idx = 4'd14; w_rom_dur = 6'd2;  end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_select     = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_done       = 1'b0;
    w_dur_dec    = 1'b0;
    w_gap_dec    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_pend) begin
          w_select     = 1'b1;
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_preempt) begin
          w_select = 1'b1;
        end else begin
          w_load       = 1'b1;
          w_next_state = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_preempt) begin
          w_select     = 1'b1;
          w_next_state = S_LOAD;
        end else if (bus.startOfFrame) begin
          w_dur_dec = 1'b1;
          if (r_dur_cnt == 6'd1) begin
            if (w_rom_last) begin
              w_done       = 1'b1;
              w_next_state = S_IDLE;
            end else begin
              w_advance    = 1'b1;
              w_next_state = (c_gap_frames == 6'd0) ? S_LOAD : S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (w_preempt) begin
          w_select     = 1'b1;
          w_next_state = S_LOAD;
        end else if (bus.startOfFrame) begin
          w_gap_dec = 1'b1;
          if (r_gap_cnt == 6'd1) w_next_state = S_LOAD;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.tone_en = (r_state == S_PLAY);
    bus.busy    = (r_state != S_IDLE);
  end

  assign bus.tone_idx  = r_tone_idx;
  assign bus.cur_event = r_cur_event;
  assign bus.seq_done  = r_seq_done;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_in_d      <= 4'd0;
      r_pend      <= 4'd0;
      r_cur_event <= 2'd0;
      r_note_ptr  <= 2'd0;
      r_dur_cnt   <= 6'd0;
      r_gap_cnt   <= 6'd0;
      r_tone_idx  <= '0;
      r_seq_done  <= 1'b0;
    end else begin
      r_in_d     <= w_in;
      r_seq_done <= w_done;
      // Selection clears before a same-edge rise can re-set: one-deep per event
      for (int i = 0; i < 4; i++) begin
        if (w_select && (w_sel_ev == 2'(i))) r_pend[i] <= 1'b0;
        else if (w_rise[i])                   r_pend[i] <= 1'b1;
      end
      if (w_select) begin
        r_cur_event <= w_sel_ev;
        r_note_ptr  <= 2'd0;
      end
      if (w_load) begin
        r_tone_idx <= TONE_W'(w_rom_idx);
        r_dur_cnt  <= w_rom_dur;
      end
      if (w_dur_dec) r_dur_cnt <= r_dur_cnt - 6'd1;
      if (w_advance) begin
        r_note_ptr <= r_note_ptr + 2'd1;
        r_gap_cnt  <= c_gap_frames;
      end
      if (w_gap_dec) r_gap_cnt <= r_gap_cnt - 6'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_game_sound_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_game_sound_sequencer                                      |
// | Description : Scoreboard bench for game_sound_sequencer; notes are queued  |
// |               when events are driven and popped as each note ends.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_game_sound_sequencer;
  localparam int TONE_W = 4;
  localparam int FRAME  = 100;

  typedef struct packed {
    logic [1:0] ev;
    logic [3:0] idx;
    logic [7:0] frames;
    logic [7:0] gap;
  } note_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  game_sound_sequencer_if #(.TONE_W(TONE_W)) bus ();

  game_sound_sequencer #(.GAP_FRAMES(1), .TONE_W(TONE_W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_done = 0;
  int    cyc    = 0;
  note_t exp_q[$];
  note_t cap;
  note_t exp_n;
  bit    in_note = 1'b0;
  logic [7:0] gapc = 8'd0;

  function automatic note_t mk(input int ev, input int idx, input int fr, input int gap);
    note_t n;
    n.ev     = 2'(ev);
    n.idx    = 4'(idx);
    n.frames = 8'(fr);
    n.gap    = 8'(gap);
    return n;
  endfunction

  initial begin
    bus.startOfFrame = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.startOfFrame = (cyc % FRAME == 0);
    end
  end

  // Note monitor: a note spans tone_en high; frames are the startOfFrame pulses sampled in it
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (in_note && !bus.tone_en) begin
        in_note = 1'b0;
        gapc    = 8'd0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL note_unexpected: got ev=%0d idx=%0d frames=%0d gap=%0d, required none",
                   cap.ev, cap.idx, cap.frames, cap.gap);
        end else begin
          exp_n = exp_q.pop_front();
          if (cap !== exp_n) begin
            n_fail++;
            $display("FAIL note: got ev=%0d idx=%0d frames=%0d gap=%0d, required ev=%0d idx=%0d frames=%0d gap=%0d",
                     cap.ev, cap.idx, cap.frames, cap.gap, exp_n.ev, exp_n.idx, exp_n.frames, exp_n.gap);
          end
        end
      end
      if (!in_note && bus.tone_en) begin
        in_note    = 1'b1;
        cap.ev     = bus.cur_event;
        cap.idx    = bus.tone_idx;
        cap.frames = 8'd0;
        cap.gap    = gapc;
      end
      if (bus.tone_en && bus.startOfFrame)                   cap.frames = cap.frames + 8'd1;
      else if (bus.busy && !bus.tone_en && bus.startOfFrame) gapc = gapc + 8'd1;
      if (!bus.busy) gapc = 8'd0;
      if (bus.seq_done) n_done++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_frame_plus(input int n);
    do @(negedge clk); while (!bus.startOfFrame);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_seq_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.seq_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_scored();
    exp_q.push_back(mk(0, 8, 6, 0));
    exp_q.push_back(mk(0, 10, 6, 1));
  endtask

  task automatic push_win();
    exp_q.push_back(mk(1, 8, 10, 0));
    exp_q.push_back(mk(1, 10, 10, 1));
    exp_q.push_back(mk(1, 12, 10, 1));
    exp_q.push_back(mk(1, 15, 20, 1));
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.tone_en, bus.tone_idx, bus.busy, bus.cur_event, bus.seq_done} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b idx=%0d busy=%b ev=%0d done=%b, required all 0",
               bus.tone_en, bus.tone_idx, bus.busy, bus.cur_event, bus.seq_done);
    end
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_scored_hold();
    bit ok;
    int done0 = n_done;
    wait_frame_plus(10);
    bus.scoredPulse = 1'b1;
    push_scored();
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.tone_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL lat_e: got busy=%b en=%b, required 0 0", bus.busy, bus.tone_en);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.tone_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL lat_e1: got busy=%b en=%b, required 1 0", bus.busy, bus.tone_en);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.tone_en, bus.tone_idx, bus.cur_event} !== {1'b1, 4'd8, 2'd0}) begin
      n_fail++;
      $display("FAIL lat_e2: got en=%b idx=%0d ev=%0d, required 1 8 0", bus.tone_en, bus.tone_idx, bus.cur_event);
    end
    repeat (2) @(negedge clk);
    bus.scoredPulse = 1'b0;
    wait_seq_done(2000, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL scored_done: got timeout, required seq_done");
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.seq_done, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL scored_after: got done=%b busy=%b, required 0 0", bus.seq_done, bus.busy);
    end
    repeat (300) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0 || n_done - done0 != 1) begin
      n_fail++;
      $display("FAIL scored_retrigger: got busy=%b queued=%0d dones=%0d, required 0 0 1",
               bus.busy, exp_q.size(), n_done - done0);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int done0 = n_done;
    wait_frame_plus(10);
    bus.winPulse    = 1'b1;
    bus.scoredPulse = 1'b1;
    push_win();
    push_scored();
    @(negedge clk);
    bus.winPulse    = 1'b0;
    bus.scoredPulse = 1'b0;
    wait_seq_done(6000, ok);
    n_cmp++;
    if (!ok || bus.cur_event !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_win_done: got ok=%b ev=%0d, required 1 1", ok, bus.cur_event);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.cur_event} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL simul_next: got busy=%b ev=%0d, required 1 0", bus.busy, bus.cur_event);
    end
    wait_seq_done(2000, ok);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (!ok || exp_q.size() != 0 || n_done - done0 != 2) begin
      n_fail++;
      $display("FAIL simul_end: got ok=%b queued=%0d dones=%0d, required 1 0 2", ok, exp_q.size(), n_done - done0);
    end
  endtask

  task automatic test_preempt();
    bit ok;
    int done0 = n_done;
    wait_frame_plus(10);
    bus.scoredPulse = 1'b1;
    exp_q.push_back(mk(0, 8, 2, 0));
    exp_q.push_back(mk(2, 7, 15, 0));
    exp_q.push_back(mk(2, 5, 15, 1));
    exp_q.push_back(mk(2, 3, 15, 1));
    exp_q.push_back(mk(2, 0, 30, 1));
    @(negedge clk);
    bus.scoredPulse = 1'b0;
    wait_frame_plus(10);
    wait_frame_plus(10);
    bus.losePulse = 1'b1;
    @(negedge clk);
    bus.losePulse = 1'b0;
    n_cmp++;
    if ({bus.tone_en, bus.cur_event} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL preempt_l: got en=%b ev=%0d, required 1 0", bus.tone_en, bus.cur_event);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.tone_en, bus.busy, bus.cur_event} !== {1'b0, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL preempt_l1: got en=%b busy=%b ev=%0d, required 0 1 2", bus.tone_en, bus.busy, bus.cur_event);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.tone_en, bus.tone_idx} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL preempt_l2: got en=%b idx=%0d, required 1 7", bus.tone_en, bus.tone_idx);
    end
    wait_seq_done(9000, ok);
    repeat (300) @(negedge clk);
    n_cmp++;
    if (!ok || bus.busy !== 1'b0 || exp_q.size() != 0 || n_done - done0 != 1) begin
      n_fail++;
      $display("FAIL preempt_end: got ok=%b busy=%b queued=%0d dones=%0d, required 1 0 0 1",
               ok, bus.busy, exp_q.size(), n_done - done0);
    end
  endtask

  task automatic test_replay_once();
    bit ok;
    int done0 = n_done;
    wait_frame_plus(10);
    bus.winPulse = 1'b1;
    push_win();
    push_scored();
    @(negedge clk);
    bus.winPulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_frame_plus(30);
      bus.scoredPulse = 1'b1;
      @(negedge clk);
      bus.scoredPulse = 1'b0;
    end
    wait_seq_done(6000, ok);
    n_cmp++;
    if (!ok || bus.cur_event !== 2'd1) begin
      n_fail++;
      $display("FAIL replay_win_done: got ok=%b ev=%0d, required 1 1", ok, bus.cur_event);
    end
    wait_seq_done(2000, ok);
    repeat (500) @(negedge clk);
    n_cmp++;
    if (!ok || bus.busy !== 1'b0 || exp_q.size() != 0 || n_done - done0 != 2) begin
      n_fail++;
      $display("FAIL replay_end: got ok=%b busy=%b queued=%0d dones=%0d, required 1 0 0 2",
               ok, bus.busy, exp_q.size(), n_done - done0);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    int busy_cnt = 0;
    wait_frame_plus(10);
    bus.winPulse = 1'b1;
    exp_q.push_back(mk(1, 8, 10, 0));
    exp_q.push_back(mk(1, 10, 10, 1));
    exp_q.push_back(mk(1, 12, 1, 1));
    @(negedge clk);
    bus.winPulse = 1'b0;
    wait_frame_plus(20);
    bus.scoredPulse = 1'b1;
    @(negedge clk);
    bus.scoredPulse = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.tone_en && bus.tone_idx == 4'd12) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_note3: got timeout, required win note idx 12");
    end
    wait_frame_plus(20);
    #3;
    resetN = 1'b0;
    #1;
    n_cmp++;
    if ({bus.tone_en, bus.busy, bus.cur_event, bus.tone_idx} !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_async: got en=%b busy=%b ev=%0d idx=%0d, required all 0",
               bus.tone_en, bus.busy, bus.cur_event, bus.tone_idx);
    end
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.busy || bus.tone_en) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_idle: got active_cycles=%0d queued=%0d, required 0 0", busy_cnt, exp_q.size());
    end
  endtask

`ifdef SOUND_COLLISION_EN
  task automatic test_collision();
    bit ok;
    wait_frame_plus(10);
    bus.collisionPulse = 1'b1;
    exp_q.push_back(mk(3, 14, 2, 0));
    @(negedge clk);
    bus.collisionPulse = 1'b0;
    wait_seq_done(500, ok);
    n_cmp++;
    if (!ok || bus.cur_event !== 2'd3) begin
      n_fail++;
      $display("FAIL coll_idle: got ok=%b ev=%0d, required 1 3", ok, bus.cur_event);
    end
    wait_frame_plus(10);
    bus.scoredPulse = 1'b1;
    push_scored();
    @(negedge clk);
    bus.scoredPulse = 1'b0;
    wait_frame_plus(10);
    bus.collisionPulse = 1'b1;
    @(negedge clk);
    bus.collisionPulse = 1'b0;
    wait_seq_done(2000, ok);
    repeat (500) @(negedge clk);
    n_cmp++;
    if (!ok || bus.busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL coll_busy: got ok=%b busy=%b queued=%0d, required 1 0 0", ok, bus.busy, exp_q.size());
    end
  endtask
`endif

  initial begin
    bus.winPulse    = 1'b0;
    bus.losePulse   = 1'b0;
    bus.scoredPulse = 1'b0;
`ifdef SOUND_COLLISION_EN
    bus.collisionPulse = 1'b0;
`endif
    test_reset();
    test_scored_hold();
    test_simultaneous();
    test_preempt();
    test_replay_once();
    test_async_reset();
`ifdef SOUND_COLLISION_EN
    test_collision();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
